// File: rtl/div_iter_pkg.sv
// div_iter_pkg: state codes and handshake constants shared by the iterative divider
package div_iter_pkg;
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
endpackage

// File: rtl/div_iter_sign_fix.sv
// div_sign_fix: conditional two's-complement negate (neg: negate a, a: value in, y: result)
module div_sign_fix
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  assign y = neg ? -a : a;
endmodule

// File: rtl/div_iter.sv
// div_iter: radix-2 restoring divider, start/ready handshake, {remainder, quotient} out (clk, rst async, signed_div_i, opdata1_i, opdata2_i, start_i, annul_i -> result_o, ready_o, busy_o, div_by_zero_o)
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_by_zero_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
  div_state_e state;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH:0] acc;
  logic [WIDTH-1:0] dvs, mag1, mag2, quo, rem;
  logic [WIDTH:0] sub;
  logic neg_q, neg_r;
  div_sign_fix #(.WIDTH(WIDTH)) u_mag1 (.neg(signed_div_i & opdata1_i[WIDTH-1]), .a(opdata1_i), .y(mag1));
  div_sign_fix #(.WIDTH(WIDTH)) u_mag2 (.neg(signed_div_i & opdata2_i[WIDTH-1]), .a(opdata2_i), .y(mag2));
  div_sign_fix #(.WIDTH(WIDTH)) u_quo (.neg(neg_q), .a(acc[WIDTH-1:0]), .y(quo));
  div_sign_fix #(.WIDTH(WIDTH)) u_rem (.neg(neg_r), .a(acc[2*WIDTH:WIDTH+1]), .y(rem));
  // The partial remainder window is always below twice the divisor, so the
  // top bit of this WIDTH+1-bit difference alone signals a failed trial.
  assign sub = acc[2*WIDTH:WIDTH] - {1'b0, dvs};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= DivFree;
      cnt           <= '0;
      acc           <= '0;
      dvs           <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      result_o      <= '0;
      ready_o       <= DivResultNotReady;
      busy_o        <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      ready_o       <= DivResultNotReady;
      div_by_zero_o <= 1'b0;
      case (state)
        DivFree: if (start_i == DivStart && !annul_i) begin
          state  <= (opdata2_i == '0) ? DivByZero : DivOn;
          busy_o <= 1'b1;
          cnt    <= '0;
          // A zero divisor keeps the raw dividend here as the final remainder.
          acc    <= {{WIDTH{1'b0}}, (opdata2_i == '0) ? opdata1_i : mag1, 1'b0};
          dvs    <= mag2;
          neg_q  <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
          neg_r  <= signed_div_i & opdata1_i[WIDTH-1];
        end
        DivByZero: if (cnt == '0) cnt <= cnt + 1'b1;
        else begin
          state         <= DivEnd;
          busy_o        <= 1'b0;
          ready_o       <= DivResultReady;
          div_by_zero_o <= 1'b1;
          result_o      <= {acc[WIDTH:1], {WIDTH{1'b1}}};
        end
        DivOn: if (annul_i) begin
          state  <= DivFree;
          busy_o <= 1'b0;
        end else if (cnt == LAST) begin
          state    <= DivEnd;
          busy_o   <= 1'b0;
          ready_o  <= DivResultReady;
          result_o <= {rem, quo};
        end else begin
          acc <= sub[WIDTH] ? {acc[2*WIDTH-1:0], 1'b0} : {sub[WIDTH-1:0], acc[WIDTH-1:0], 1'b1};
          cnt <= cnt + 1'b1;
        end
        default: state <= DivFree;
      endcase
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: randomized and directed checks of div_iter against an arithmetic model
module tb_div_iter;
  logic clk = 1'b0, rst = 1'b1;
  logic sd32 = 1'b0, start32 = 1'b0, annul32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] res32;
  logic rdy32, busy32, dbz32;
  logic sd8 = 1'b0, start8 = 1'b0, annul8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] res8;
  logic rdy8, busy8, dbz8;
  int n_checks = 0, n_fail = 0;
  logic [63:0] last32 = '0;
  always #5 clk = ~clk;
  div_iter #(.WIDTH(32), .CNT_W(6)) dut32 (
    .clk(clk), .rst(rst), .signed_div_i(sd32), .opdata1_i(a32), .opdata2_i(b32),
    .start_i(start32), .annul_i(annul32), .result_o(res32), .ready_o(rdy32),
    .busy_o(busy32), .div_by_zero_o(dbz32));
  div_iter #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst), .signed_div_i(sd8), .opdata1_i(a8), .opdata2_i(b8),
    .start_i(start8), .annul_i(annul8), .result_o(res8), .ready_o(rdy8),
    .busy_o(busy8), .div_by_zero_o(dbz8));

  function automatic logic [63:0] model(input int w, input bit sd, input logic [31:0] a, input logic [31:0] b);
    longint m, ua, ub, sa, sb, q, r;
    m  = (longint'(1) << w) - 1;
    ua = longint'(a) & m;
    ub = longint'(b) & m;
    if (ub == 0) begin
      q = m;
      r = ua;
    end else if (!sd) begin
      q = ua / ub;
      r = ua % ub;
    end else begin
      sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
      sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
      q = sa / sb;
      r = sa % sb;
    end
    return 64'(((r & m) << w) | (q & m));
  endfunction

  task automatic run_div(input bit w8, input bit sd, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat, output logic dbz, output int bcnt);
    @(negedge clk);
    if (w8) begin sd8 = sd; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1; end
    else begin sd32 = sd; a32 = a; b32 = b; start32 = 1'b1; end
    @(posedge clk);
    #1;
    start8 = 1'b0; start32 = 1'b0;
    sd8 = ~sd; sd32 = ~sd; a8 = 8'($urandom); b8 = 8'($urandom); a32 = $urandom; b32 = $urandom;
    lat = -1; bcnt = 0; res = '0; dbz = 1'b0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (w8 ? busy8 : busy32) bcnt++;
      if (w8 ? rdy8 : rdy32) begin
        lat = j;
        res = w8 ? {48'b0, res8} : res32;
        dbz = w8 ? dbz8 : dbz32;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({res32, rdy32, busy32, dbz32} !== 67'b0) begin n_fail++; $display("FAIL reset32: got %h expected 0", {res32, rdy32, busy32, dbz32}); end
    n_checks++;
    if ({res8, rdy8, busy8, dbz8} !== 19'b0) begin n_fail++; $display("FAIL reset8: got %h expected 0", {res8, rdy8, busy8, dbz8}); end
    rst = 1'b0;
  endtask

  task automatic test_unsigned;
    logic [63:0] r; int lat, bc; logic z;
    run_div(0, 0, 32'd100, 32'd7, r, lat, z, bc);
    n_checks++;
    if (r !== {32'd2, 32'd14} || z !== 1'b0) begin n_fail++; $display("FAIL unsigned_100_7: got %h dbz %b expected %h dbz 0", r, z, {32'd2, 32'd14}); end
    n_checks++;
    if (lat != 33) begin n_fail++; $display("FAIL unsigned_latency: got %0d expected 33", lat); end
    n_checks++;
    if (bc != 33) begin n_fail++; $display("FAIL unsigned_busy_cycles: got %0d expected 33", bc); end
    @(negedge clk);
    n_checks++;
    if (rdy32 !== 1'b0 || res32 !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL ready_pulse_hold: got rdy %b res %h expected rdy 0 res %h", rdy32, res32, {32'd2, 32'd14}); end
    last32 = {32'd2, 32'd14};
  endtask

  task automatic test_signed;
    logic [63:0] r; int lat, bc; logic z;
    run_div(0, 1, 32'hFFFF_FFF9, 32'd2, r, lat, z, bc);
    n_checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFD || lat != 33) begin n_fail++; $display("FAIL signed_m7_2: got %h lat %0d expected ffffffff_fffffffd lat 33", r, lat); end
    run_div(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, z, bc);
    n_checks++;
    if (r !== 64'h0000_0000_8000_0000 || z !== 1'b0) begin n_fail++; $display("FAIL signed_min_m1: got %h dbz %b expected 00000000_80000000 dbz 0", r, z); end
    last32 = 64'h0000_0000_8000_0000;
  endtask

  task automatic test_div_zero;
    logic [63:0] r; int lat, bc; logic z;
    run_div(0, 0, 32'h1234, 32'd0, r, lat, z, bc);
    n_checks++;
    if (r !== 64'h0000_1234_FFFF_FFFF || z !== 1'b1) begin n_fail++; $display("FAIL div_zero: got %h dbz %b expected 00001234_ffffffff dbz 1", r, z); end
    n_checks++;
    if (lat != 2) begin n_fail++; $display("FAIL div_zero_latency: got %0d expected 2", lat); end
    last32 = 64'h0000_1234_FFFF_FFFF;
  endtask

  task automatic test_annul;
    logic [63:0] r; int lat, bc, pulses; logic z;
    @(negedge clk);
    sd32 = 1'b0; a32 = 32'd1000; b32 = 32'd3; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (11) @(negedge clk);
    annul32 = 1'b1;
    @(negedge clk);
    annul32 = 1'b0;
    n_checks++;
    if (busy32 !== 1'b0) begin n_fail++; $display("FAIL annul_idle: got busy %b expected 0", busy32); end
    pulses = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (rdy32) pulses++;
    end
    n_checks++;
    if (pulses != 0 || res32 !== last32) begin n_fail++; $display("FAIL annul_no_result: got pulses %0d res %h expected 0 res %h", pulses, res32, last32); end
    run_div(0, 0, 32'd9, 32'd3, r, lat, z, bc);
    n_checks++;
    if (r !== {32'd0, 32'd3} || lat != 33) begin n_fail++; $display("FAIL after_annul_9_3: got %h lat %0d expected %h lat 33", r, lat, {32'd0, 32'd3}); end
    last32 = {32'd0, 32'd3};
  endtask

  task automatic test_async_reset;
    int pulses;
    @(negedge clk);
    sd32 = 1'b0; a32 = 32'd1000; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({res32, rdy32, busy32, dbz32} !== 67'b0) begin n_fail++; $display("FAIL async_reset: got %h expected 0", {res32, rdy32, busy32, dbz32}); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int j = 0; j < 45; j++) begin
      @(negedge clk);
      if (rdy32) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL reset_discard: got %0d pulses expected 0", pulses); end
    last32 = '0;
  endtask

  task automatic test_start_held;
    int pulses, lat;
    @(negedge clk);
    sd32 = 1'b0; a32 = 32'd50; b32 = 32'd5; start32 = 1'b1;
    lat = -1;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (rdy32) begin lat = j; break; end
    end
    n_checks++;
    if (lat != 33 || res32 !== {32'd0, 32'd10}) begin n_fail++; $display("FAIL held_result: got lat %0d res %h expected lat 33 res %h", lat, res32, {32'd0, 32'd10}); end
    @(negedge clk);
    n_checks++;
    if (busy32 !== 1'b0 || rdy32 !== 1'b0) begin n_fail++; $display("FAIL held_no_restart_in_end: got busy %b rdy %b expected 0 0", busy32, rdy32); end
    start32 = 1'b0;
    pulses = 0;
    for (int j = 0; j < 45; j++) begin
      @(negedge clk);
      if (rdy32) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL held_single_pulse: got %0d extra pulses expected 0", pulses); end
    last32 = {32'd0, 32'd10};
  endtask

  task automatic test_w8;
    logic [63:0] r; int lat, bc; logic z;
    run_div(1, 0, 32'd200, 32'd13, r, lat, z, bc);
    n_checks++;
    if (r !== 64'h0000_0000_0000_050F || lat != 9) begin n_fail++; $display("FAIL w8_200_13: got %h lat %0d expected 050f lat 9", r, lat); end
  endtask

  task automatic test_random;
    logic [63:0] r, exp_r; int lat, bc, exp_lat, w; logic z; bit w8, sd; logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      w8 = i[0];
      w  = w8 ? 8 : 32;
      sd = 1'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 28);
      if (i % 10 == 3) begin a = w8 ? 32'h80 : 32'h8000_0000; b = 32'hFFFF_FFFF; sd = 1'b1; end
      run_div(w8, sd, a, b, r, lat, z, bc);
      exp_r   = model(w, sd, a, b);
      exp_lat = ((w8 ? {24'b0, b[7:0]} : b) == 32'd0) ? 2 : w + 1;
      n_checks++;
      if (r !== exp_r || lat != exp_lat || z !== (exp_lat == 2)) begin
        n_fail++;
        $display("FAIL random_w%0d_s%0d a=%h b=%h: got %h lat %0d dbz %b expected %h lat %0d", w, sd, a, b, r, lat, z, exp_r, exp_lat);
      end
    end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_annul;
    test_async_reset;
    test_start_held;
    test_w8;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
